// File: rtl/arbitro_framebuffer_pkg.sv
// Shared video constants and types for the framebuffer arbiter and its scanout address generator.
package pkg_video;

  localparam int FB_W       = 160;
  localparam int FB_H       = 120;
  localparam int PIX_W      = 8;
  localparam int LOG2_SCALE = 2;
  localparam int FB_SIZE    = FB_W * FB_H;
  localparam int ADDR_W     = $clog2(FB_SIZE);

  typedef logic [PIX_W-1:0]  pixel_t;
  typedef logic [ADDR_W-1:0] fb_addr_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    WAIT_VB = 2'd2
  } estado_arbitro_t;

  localparam fb_addr_t LAST_ADDR = fb_addr_t'(FB_SIZE - 1);

  // Row-major framebuffer address; coordinates are already in framebuffer units.
  function automatic fb_addr_t fb_addr(input logic [9:0] x, input logic [9:0] y);
    return fb_addr_t'(32'(y) * 32'(FB_W) + 32'(x));
  endfunction

endpackage

// File: rtl/arbitro_framebuffer_varredura.sv
// Scanout side of the arbiter: slot decode, read address, and the 2-cycle
// de/pixel pipeline that holds each framebuffer pixel for 2^LOG2_SCALE screen pixels.
module gerador_endereco_varredura
  import pkg_video::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] sx,
  input  logic [9:0] sy,
  input  logic       de,
  input  pixel_t     mem_rdata,
  output logic       scan_slot,
  output fb_addr_t   scan_addr,
  output pixel_t     pix_color,
  output logic       pix_de
);

  logic   de_d1;
  logic   de_d2;
  logic   slot_d1;
  pixel_t pix_hold;

  assign scan_slot = de && (sx[LOG2_SCALE-1:0] == '0);
  assign scan_addr = fb_addr(sx >> LOG2_SCALE, sy >> LOG2_SCALE);

  // Read data arrives one cycle after the slot; latch it then.
  always_ff @(posedge clock) begin
    if (reset) begin
      de_d1    <= 1'b0;
      de_d2    <= 1'b0;
      slot_d1  <= 1'b0;
      pix_hold <= '0;
    end else begin
      de_d1   <= de;
      de_d2   <= de_d1;
      slot_d1 <= scan_slot;
      if (slot_d1) pix_hold <= mem_rdata;
    end
  end

  assign pix_de    = de_d2;
  assign pix_color = de_d2 ? pix_hold : '0;

endmodule

// File: rtl/arbitro_framebuffer.sv
// Single-port framebuffer arbiter: scanout reads win, draw writes and the clear FSM share free slots.
// Optional CLEAR_VBLANK_SYNC_EN delays a clear until vertical blanking starts.
module arbitro_framebuffer
  import pkg_video::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic [9:0]      sx,
  input  logic [9:0]      sy,
  input  logic            de,
  output pixel_t          pix_color,
  output logic            pix_de,
  input  logic            draw_valid,
  output logic            draw_ready,
  input  logic [7:0]      draw_x,
  input  logic [6:0]      draw_y,
  input  pixel_t          draw_color,
  output logic            draw_drop,
  input  logic            clr_start,
  input  pixel_t          clr_color,
  output logic            busy,
  output logic            clr_done,
  output fb_addr_t        mem_addr,
  output logic            mem_we,
  output pixel_t          mem_wdata,
  input  pixel_t          mem_rdata,
  output estado_arbitro_t estado_dbg
);

  // Draw port: a beat transfers on a cycle where draw_valid && draw_ready;
  // draw_ready never looks at draw_valid, and an out-of-range beat is still consumed.

  estado_arbitro_t estado;
  fb_addr_t        clr_cnt;
  pixel_t          clr_color_q;
  logic            scan_slot;
  fb_addr_t        scan_addr;
  logic            draw_accept;
  logic            draw_in_range;
  logic            clear_write;

  gerador_endereco_varredura u_varredura (
    .clock     (clock),
    .reset     (reset),
    .sx        (sx),
    .sy        (sy),
    .de        (de),
    .mem_rdata (mem_rdata),
    .scan_slot (scan_slot),
    .scan_addr (scan_addr),
    .pix_color (pix_color),
    .pix_de    (pix_de)
  );

  assign draw_ready    = !reset && (estado == IDLE) && !scan_slot;
  assign draw_accept   = draw_valid && draw_ready;
  assign draw_in_range = (draw_x < 8'(FB_W)) && (draw_y < 7'(FB_H));
  assign clear_write   = !reset && (estado == CLEAR) && !scan_slot;
  assign estado_dbg    = estado;

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (!reset) begin
      if (scan_slot) begin
        mem_addr = scan_addr;
      end else if (clear_write) begin
        mem_addr  = clr_cnt;
        mem_we    = 1'b1;
        mem_wdata = clr_color_q;
      end else if (draw_accept && draw_in_range) begin
        mem_addr  = fb_addr({2'b00, draw_x}, {3'b000, draw_y});
        mem_we    = 1'b1;
        mem_wdata = draw_color;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado      <= IDLE;
      clr_cnt     <= '0;
      clr_color_q <= '0;
      busy        <= 1'b0;
      clr_done    <= 1'b0;
      draw_drop   <= 1'b0;
    end else begin
      clr_done  <= 1'b0;
      draw_drop <= draw_accept && !draw_in_range;
      case (estado)
        IDLE: begin
          if (clr_start) begin
            clr_color_q <= clr_color;
            clr_cnt     <= '0;
            busy        <= 1'b1;
`ifdef CLEAR_VBLANK_SYNC_EN
            estado      <= WAIT_VB;
`else
            estado      <= CLEAR;
`endif
          end
        end
`ifdef CLEAR_VBLANK_SYNC_EN
        WAIT_VB: begin
          if (sy >= 10'(FB_H << LOG2_SCALE)) estado <= CLEAR;
        end
`endif
        CLEAR: begin
          // Scan slots stall the counter; it stops at the last address.
          if (!scan_slot) begin
            if (clr_cnt == LAST_ADDR) begin
              estado   <= IDLE;
              busy     <= 1'b0;
              clr_done <= 1'b1;
            end else begin
              clr_cnt <= clr_cnt + 1'b1;
            end
          end
        end
        default: estado <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_framebuffer.sv
// Self-checking bench for arbitro_framebuffer with a 1-cycle-latency RAM model.
module tb_arbitro_framebuffer;
  import pkg_video::*;

  logic            clock = 1'b0;
  logic            reset;
  logic [9:0]      sx, sy;
  logic            de;
  pixel_t          pix_color;
  logic            pix_de;
  logic            draw_valid, draw_ready;
  logic [7:0]      draw_x;
  logic [6:0]      draw_y;
  pixel_t          draw_color;
  logic            draw_drop;
  logic            clr_start;
  pixel_t          clr_color;
  logic            busy, clr_done;
  fb_addr_t        mem_addr;
  logic            mem_we;
  pixel_t          mem_wdata, mem_rdata;
  estado_arbitro_t estado_dbg;

  arbitro_framebuffer dut (
    .clock(clock), .reset(reset), .sx(sx), .sy(sy), .de(de),
    .pix_color(pix_color), .pix_de(pix_de),
    .draw_valid(draw_valid), .draw_ready(draw_ready), .draw_x(draw_x), .draw_y(draw_y),
    .draw_color(draw_color), .draw_drop(draw_drop),
    .clr_start(clr_start), .clr_color(clr_color), .busy(busy), .clr_done(clr_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .estado_dbg(estado_dbg)
  );

  always #5 clock = ~clock;

  pixel_t ram [FB_SIZE];

  always @(posedge clock) begin
    if (mem_we && int'(mem_addr) < FB_SIZE) ram[int'(mem_addr)] <= mem_wdata;
    mem_rdata <= (int'(mem_addr) < FB_SIZE) ? ram[int'(mem_addr)] : '0;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_vga(input int x, input int y, input logic d);
    sx = 10'(x);
    sy = 10'(y);
    de = d;
  endtask

  typedef struct {
    int     x;
    int     y;
    pixel_t color;
  } scan_vec_t;

  scan_vec_t   tv [6];
  logic [8:0]  exp_q [$];
  logic [8:0]  e;
  int          busy_cnt, done_cnt, wr_cnt, first_wr, post, err_wr, err_scan, err_rdy, bad_words;
  int          hcnt, vcnt;
  logic        fin, slot;

  initial begin
    for (int k = 0; k < FB_SIZE; k++) ram[k] = 8'(k);
    tv[0] = '{0,   0,   8'h00};
    tv[1] = '{8,   0,   8'h02};
    tv[2] = '{8,   4,   8'hA2};
    tv[3] = '{4,   8,   8'h41};
    tv[4] = '{320, 240, 8'hD0};
    tv[5] = '{636, 479, 8'hFF};

    reset = 1'b1; draw_valid = 1'b0; draw_x = '0; draw_y = '0; draw_color = '0;
    clr_start = 1'b0; clr_color = '0;
    set_vga(8, 0, 1'b1);
    repeat (3) tick;
    #1;
    check("rst_pix_color", pix_color, 0);
    check("rst_pix_de", pix_de, 0);
    check("rst_busy", busy, 0);
    check("rst_clr_done", clr_done, 0);
    check("rst_draw_drop", draw_drop, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_draw_ready", draw_ready, 0);
    check("rst_state", 32'(estado_dbg), 32'(IDLE));
    set_vga(700, 500, 1'b0);
    tick;
    reset = 1'b0;
    tick;

    // Scanout: 4 active cycles per vector then 2 blank cycles; expectations 2 cycles late.
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < 6; k++) begin
        if (k < 4) set_vga(tv[v].x + k, tv[v].y, 1'b1);
        else       set_vga(700, tv[v].y, 1'b0);
        exp_q.push_back((k < 4) ? {1'b1, tv[v].color} : 9'h000);
        #1;
        if (exp_q.size() > 2) begin
          e = exp_q.pop_front();
          check($sformatf("scan_v%0d", v), {pix_de, pix_color}, e);
        end
        tick;
      end
    end
    for (int k = 0; k < 2; k++) begin
      set_vga(700, 500, 1'b0);
      exp_q.push_back(9'h000);
      #1;
      e = exp_q.pop_front();
      check("scan_flush", {pix_de, pix_color}, e);
      tick;
    end

    // Draw held across a scan slot, then accepted in the next free cycle.
    draw_valid = 1'b1; draw_x = 8'd10; draw_y = 7'd5; draw_color = 8'hA5;
    set_vga(4, 0, 1'b1);
    #1;
    check("draw_ready_in_slot", draw_ready, 0);
    check("slot_no_we", mem_we, 0);
    check("slot_addr", 32'(mem_addr), 1);
    tick;
    set_vga(5, 0, 1'b1);
    #1;
    check("draw_ready_free", draw_ready, 1);
    check("draw_we", mem_we, 1);
    check("draw_addr", 32'(mem_addr), 810);
    check("draw_wdata", mem_wdata, 8'hA5);
    tick;
    draw_valid = 1'b0;
    set_vga(700, 500, 1'b0);
    #1;
    check("draw_ram810", ram[810], 8'hA5);
    check("draw_no_drop", draw_drop, 0);

    // Range boundaries: x=160 and y=120 drop, (159,119) writes the last word.
    draw_valid = 1'b1; draw_x = 8'd160; draw_y = 7'd0; draw_color = 8'h11;
    #1;
    check("drop_x_ready", draw_ready, 1);
    check("drop_x_no_we", mem_we, 0);
    tick;
    draw_x = 8'd0; draw_y = 7'd120;
    #1;
    check("drop_x_pulse", draw_drop, 1);
    check("drop_y_no_we", mem_we, 0);
    tick;
    draw_x = 8'd159; draw_y = 7'd119; draw_color = 8'h5A;
    #1;
    check("drop_y_pulse", draw_drop, 1);
    check("edge_we", mem_we, 1);
    check("edge_addr", 32'(mem_addr), 19199);
    tick;
    draw_valid = 1'b0;
    #1;
    check("edge_no_drop", draw_drop, 0);
    tick;
    #1;
    check("drop_single_pulse", draw_drop, 0);

    // Reset in the middle of a clear aborts it silently.
    clr_start = 1'b1; clr_color = 8'h44;
    tick;
    clr_start = 1'b0;
    repeat (40) tick;
    #1;
    check("abort_busy_before", busy, 1);
    reset = 1'b1;
    tick;
    #1;
    check("abort_busy_after", busy, 0);
    check("abort_state", 32'(estado_dbg), 32'(IDLE));
    reset = 1'b0;
    done_cnt = 0; wr_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick;
      #1;
      if (clr_done) done_cnt++;
      if (mem_we) wr_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    check("abort_no_writes", wr_cnt, 0);

    // Clear during blanking, started together with an accepted draw.
    set_vga(700, 500, 1'b0);
    draw_valid = 1'b1; draw_x = 8'd3; draw_y = 7'd0; draw_color = 8'h99;
    clr_start = 1'b1; clr_color = 8'h3C;
    #1;
    check("same_cycle_we", mem_we, 1);
    check("same_cycle_addr", 32'(mem_addr), 3);
    check("same_cycle_wdata", mem_wdata, 8'h99);
    check("same_cycle_busy", busy, 0);
    tick;
    clr_start = 1'b0; draw_x = 8'd200; draw_color = 8'hEE;
    busy_cnt = 0; done_cnt = 0; wr_cnt = 0; first_wr = -1; post = 0;
    err_wr = 0; err_rdy = 0; fin = 1'b0;
    for (int i = 0; i < 25000 && !fin; i++) begin
      #1;
      if (busy) busy_cnt++;
      if (busy && draw_ready) err_rdy++;
      if (mem_we) begin
        if (first_wr < 0) first_wr = i;
        if (int'(mem_addr) != wr_cnt || mem_wdata != 8'h3C) err_wr++;
        wr_cnt++;
      end
      if (clr_done) done_cnt++;
      if (done_cnt > 0) post++;
      if (post >= 3) fin = 1'b1;
      tick;
    end
    draw_valid = 1'b0;
`ifdef CLEAR_VBLANK_SYNC_EN
    check("clr1_busy_cycles", busy_cnt, 19201);
    check("clr1_first_write", first_wr, 1);
`else
    check("clr1_busy_cycles", busy_cnt, 19200);
    check("clr1_first_write", first_wr, 0);
`endif
    check("clr1_writes", wr_cnt, 19200);
    check("clr1_write_order", err_wr, 0);
    check("clr1_done_count", done_cnt, 1);
    check("clr1_ready_while_busy", err_rdy, 0);
    bad_words = 0;
    for (int k = 0; k < FB_SIZE; k++) if (ram[k] != 8'h3C) bad_words++;
    check("clr1_ram_words", bad_words, 0);
    repeat (2) tick;

    // Clear during active video with a second clr_start mid-clear.
    hcnt = 0;
`ifdef CLEAR_VBLANK_SYNC_EN
    vcnt = 476;
`else
    vcnt = 0;
`endif
    done_cnt = 0; wr_cnt = 0; first_wr = -1; post = 0; err_wr = 0; err_scan = 0; fin = 1'b0;
    for (int i = 0; i < 60000 && !fin; i++) begin
      set_vga(hcnt, vcnt, hcnt < 640 && vcnt < 480);
      clr_start = (i == 0) || (i == 1000);
      clr_color = (i == 0) ? 8'h55 : 8'h77;
      #1;
      slot = de && (sx[1:0] == 2'b00);
      if (slot && (mem_we || int'(mem_addr) != (vcnt / 4) * 160 + hcnt / 4)) err_scan++;
      if (mem_we) begin
        if (first_wr < 0) first_wr = i;
        if (int'(mem_addr) != wr_cnt || mem_wdata != 8'h55) err_wr++;
        wr_cnt++;
      end
      if (clr_done) done_cnt++;
      if (done_cnt > 0) post++;
      if (post >= 3) fin = 1'b1;
      tick;
      hcnt++;
      if (hcnt == 648) begin
        hcnt = 0;
        vcnt = (vcnt == 489) ? 0 : vcnt + 1;
      end
    end
    clr_start = 1'b0;
    set_vga(700, 500, 1'b0);
`ifndef CLEAR_VBLANK_SYNC_EN
    check("clr2_first_write", first_wr, 1);
`endif
    check("clr2_scan_slots_clean", err_scan, 0);
    check("clr2_write_order", err_wr, 0);
    check("clr2_writes", wr_cnt, 19200);
    check("clr2_done_count", done_cnt, 1);
    bad_words = 0;
    for (int k = 0; k < FB_SIZE; k++) if (ram[k] != 8'h55) bad_words++;
    check("clr2_ram_words", bad_words, 0);

`ifdef CLEAR_VBLANK_SYNC_EN
    // Clear requested at sy=100 must not write before blanking begins.
    tick;
    set_vga(700, 100, 1'b0);
    clr_start = 1'b1; clr_color = 8'h66;
    tick;
    clr_start = 1'b0;
    err_wr = 0;
    for (int y = 101; y <= 480; y++) begin
      set_vga(700, y, 1'b0);
      #1;
      if (mem_we || !busy) err_wr++;
      tick;
    end
    set_vga(700, 481, 1'b0);
    #1;
    check("vb_no_early_write", err_wr, 0);
    check("vb_first_write", mem_we, 1);
    check("vb_first_addr", 32'(mem_addr), 0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
